// File: rtl/mc_controller.sv
// Multicycle LEGv8 control FSM (LDUR/STUR/CBZ/B/ADD/SUB/AND/ORR) with a req/ready memory port.
// Optional memory wait timeout enabled by defining MC_MEM_TIMEOUT_EN.
module mc_controller #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] op,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [3:0]  state,
    output logic        illegal,
    output logic        bus_err
);

    localparam int unsigned WAIT_W = 8;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mc_controller: TIMEOUT must be in 2..255");
    end

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_TRAP   = 4'd10
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q;
    logic   timeout_c;

    // State register; illegal stays set once TRAP is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_q | (state_d == S_TRAP);
        end
    end

`ifdef MC_MEM_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              bus_err_q;
    logic              waiting_c;

    // Counter restarts whenever the FSM changes state, i.e. on entry to any access state.
    always_comb begin
        waiting_c = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                    && !mem_ready;
        timeout_c = waiting_c && (wait_q == WAIT_LAST);
        wait_d    = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (waiting_c) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            bus_err_q <= bus_err_q | timeout_c;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_c = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Next-state and per-state control outputs; everything held low during reset.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (timeout_c) begin
                        state_d = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    casez (op)
                        11'b11111000010,
                        11'b11111000000: state_d = S_MEMADR;
                        11'b10001011000,
                        11'b11001011000,
                        11'b10001010000,
                        11'b10101010000: state_d = S_EXEC;
                        11'b10110100???: state_d = S_BRANCH;
                        11'b000101?????: state_d = S_JUMP;
                        default:         state_d = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = op[1] ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        mdr_we  = 1'b1;
                        state_d = S_MEMWB;
                    end else if (timeout_c) begin
                        state_d = S_TRAP;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end else if (timeout_c) begin
                        state_d = S_TRAP;
                    end
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 1'b1;
                    pc_we     = zero;
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    pc_src  = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_FETCH;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_TRAP;
            endcase
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle control FSM for the LEGv8 subset: LDUR, STUR, CBZ, B, ADD, SUB, AND, ORR.
- Sequences the 64-bit resettable register datapath (PC, IR, A/B, ALUOut, MDR) by driving their write enables and the datapath mux selects.
- Talks to a shared instruction/data memory through a req/ready handshake.
- Replaces the single-cycle main decoder when the processor is built in multicycle form.

Parameters:
- TIMEOUT, 16, max cycles waiting on mem_ready before bus error (used only with MC_MEM_TIMEOUT_EN); legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  11  IR[31:21] opcode field
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  1 = write access (valid with mem_req)
- iord  out  1  address mux: 0 = PC, 1 = ALUOut
- ir_we  out  1  IR load enable
- mdr_we  out  1  MDR load enable
- pc_we  out  1  PC load enable
- pc_src  out  1  PC mux: 0 = ALU result, 1 = ALUOut
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback mux: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = signext imm, 11 = signext imm << 2
- alu_op  out  2  00 = add, 01 = pass B, 10 = funct from op
- state  out  4  current state encoding (debug)
- illegal  out  1  sticky unsupported-opcode flag
- bus_err  out  1  sticky memory timeout flag

Behaviour:
- Reset:
  - While reset = 0, state = FETCH(0) and every output is 0, including mem_req, illegal and bus_err.
  - Applies asynchronously mid-access; an outstanding request is abandoned.
  - mem_req rises in the first cycle after release.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, TRAP 10. Codes 11-15 go to TRAP.
- Default outputs are 0; each state asserts only what is listed below.
- FETCH:
  - mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00.
  - Holds until mem_ready; in the mem_ready cycle ir_we = 1 and pc_we = 1 (pc_src = 0), then go to DECODE.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = 00, so ALUOut captures the branch target.
  - Dispatch on op:
    - LDUR 11111000010 or STUR 11111000000 -> MEMADR
    - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> EXEC
    - op[10:3] = 10110100 (CBZ) -> BRANCH
    - op[10:5] = 000101 (B) -> JUMP
    - anything else -> TRAP
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00; go to MEMRD if op[1] = 1, else MEMWR.
- MEMRD: mem_req = 1, iord = 1; hold until mem_ready; mdr_we = 1 in the ready cycle; then MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1; then FETCH.
- MEMWR: mem_req = 1, mem_write = 1, iord = 1; hold until mem_ready; then FETCH.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10; then ALUWB.
- ALUWB: reg_write = 1, mem_to_reg = 0; then FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 1, pc_we = zero; then FETCH.
- JUMP: pc_src = 1, pc_we = 1; then FETCH.
- TRAP: illegal = 1 (sticky), all enables 0; left only by reset.
- mem_req and the address selects stay stable until the mem_ready cycle. mem_ready outside FETCH, MEMRD or MEMWR is ignored.
- Cycle counts, with a zero-wait memory (mem_ready = 1 in the request cycle):
  - LDUR 5 cycles
  - STUR 4 cycles
  - R-type 4 cycles
  - CBZ 3 cycles
  - B 3 cycles
- Each wait cycle adds 1.

Optional Feature:
- MC_MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on entry to FETCH, MEMRD or MEMWR.
  - It increments each cycle mem_req = 1 and mem_ready = 0.
  - When it reaches TIMEOUT with mem_ready still 0: bus_err = 1 (sticky), go to TRAP, drop mem_req next cycle.
  - mem_ready arriving in the same cycle the count hits TIMEOUT wins: normal completion, no error.
- Not defined: waits indefinitely, no counter logic, bus_err tied 0.

Test Plan:
- Reset held low 3 cycles during a FETCH wait -> all outputs 0, state = 0; after release, mem_req = 1 on the first edge.
- op = 11111000010 (LDUR), mem_ready always 1 -> states 0,1,2,3,4,0; mdr_we in state 3; reg_write + mem_to_reg in state 4; 5 cycles total.
- op = 11111000000 (STUR), mem_ready delayed 3 cycles in MEMWR -> mem_req + mem_write + iord held 4 cycles, then FETCH; reg_write never 1.
- op = 10110100xxx (CBZ) with zero = 1, then zero = 0 -> pc_we = 1 with pc_src = 1 in state 8, then pc_we = 0; both return to FETCH.
- op = 00000000000 -> state 10, illegal = 1, stays there 20 cycles despite mem_ready toggling; cleared only by reset.
- MC_MEM_TIMEOUT_EN with TIMEOUT = 4, mem_ready stuck 0 in FETCH -> bus_err = 1 after 4 waiting cycles, state = 10, mem_req = 0; repeat with mem_ready on the 4th cycle -> no error.
